alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Registered issue stage directly upstream of the ALU datapath: adder, logic unit, sll and sra barrel shifters.
- Accepts operand/opcode bundles over a valid/ready handshake and buffers them in a 2-entry skid buffer, so ready_in is a pure register output.
- Presents a stable registered bundle to the combinational ALU.
- Resolves the shift amount (immediate or register-sourced) and decodes the opcode into one-hot unit selects, so the shifters see a clean ctrl_shiftamt.

Parameters:
- WIDTH, 32, operand width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).
- OP_W, 5, ALU opcode width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  upstream bundle valid.
- ready_in  output  1  stage can accept a bundle; registered.
- data_operandA_in  input  WIDTH  operand A.
- data_operandB_in  input  WIDTH  operand B.
- ctrl_ALUopcode_in  input  OP_W  ALU opcode.
- ctrl_shiftamt_in  input  SHAMT_W  immediate shift amount.
- ctrl_regshift_in  input  1  1 = take shift amount from data_operandB_in[SHAMT_W-1:0].
- valid_out  output  1  output bundle valid.
- ready_out  input  1  ALU/writeback consumer ready.
- data_operandA  output  WIDTH  registered operand A.
- data_operandB  output  WIDTH  registered operand B.
- ctrl_ALUopcode  output  OP_W  registered opcode.
- ctrl_shiftamt  output  SHAMT_W  resolved shift amount.
- sel_add, sel_sub, sel_and, sel_or, sel_sll, sel_sra  output  1 each  one-hot unit select; all 0 for unrecognised opcodes.
- issue_count  output  16  number of bundles transferred out.

Behaviour:
- Transfer-in: valid_in & ready_in at a rising edge. Transfer-out: valid_out & ready_out.
- Storage is a main register (drives the outputs) plus a skid register. Occupancy is 0, 1 or 2.
- ready_in = (occupancy < 2), registered. Accepting when occupancy is 1 and no transfer-out occurs drives ready_in to 0 on the next cycle.
- Input-to-output latency is 1 cycle: a bundle accepted at edge N with occupancy 0 is visible with valid_out=1 after edge N.
- Ordering is FIFO. When the main entry transfers out and the skid is full, the skid moves to main in the same edge. A simultaneous transfer-in then lands in skid.
- Simultaneous in and out with occupancy 1: the new bundle loads main directly and occupancy stays 1.
- Shift-amount resolution happens at accept time: ctrl_shiftamt = ctrl_regshift_in ? data_operandB_in[SHAMT_W-1:0] : ctrl_shiftamt_in. The resolved value is stored, not the raw fields.
- Opcode decode happens at accept time and is stored with the bundle:
  - 00000 add
  - 00001 sub
  - 00010 and
  - 00011 or
  - 00100 sll
  - 00101 sra
  - any other opcode: all sel_* = 0, but the bundle still passes.
- Output bundle fields hold when valid_out=1 and ready_out=0. A bench checks this every stalled cycle.
- issue_count increments on each transfer-out and wraps from 0xFFFF to 0x0000.
- Reset (asynchronous assert, any time including mid-transfer):
  - occupancy 0, valid_out 0, ready_in 1;
  - all data/ctrl/sel outputs 0;
  - issue_count 0.
- Reset release is used synchronously. The first accept is possible at the first edge with reset high.
- valid_in while ready_in=0 is ignored (no capture). Upstream must hold the bundle.

Decomposition:
- Shared package alu_pkg holds the opcode constants (OP_ADD..OP_SRA), the WIDTH/SHAMT_W defaults and the bundle struct (operandA, operandB, opcode, shiftamt, sel vector).
- Sub-module alu_skid_buffer: generic 2-entry valid/ready skid buffer parameterised by payload width. It is reused for the writeback stage.
- The top level holds the decode logic, shift resolution and issue_count.

Test Plan:
- Reset then single op:
  - Stimulus: after reset, valid_in=1, A=0x0000_0001, opcode=00100, shiftamt_in=5, regshift=0, ready_out=1.
  - Response: next cycle valid_out=1, ctrl_shiftamt=5, sel_sll=1 and others 0, issue_count increments to 1.
- Register-sourced shift:
  - Stimulus: regshift=1, B=0xFFFF_FFE3, shiftamt_in=7.
  - Response: ctrl_shiftamt=3 (B[4:0]), data_operandB=0xFFFF_FFE3.
- Back-pressure fill:
  - Stimulus: ready_out=0, three consecutive valid_in bundles tagged A=1,2,3.
  - Response: first two accepted, ready_in=0 from the cycle after the second accept, bundle 3 held upstream, outputs show A=1 unchanged while stalled.
- Drain ordering:
  - Stimulus: from the full state, ready_out=1 for 4 cycles with bundle 3 still offered.
  - Response: output sequence A=1,2,3, issue_count +3, ready_in returns to 1, no bundle dropped or duplicated.
- Unrecognised opcode plus counter wrap:
  - Stimulus: preload issue_count to 0xFFFF via 65535 transfers, then send opcode 11111.
  - Response: all sel_*=0, bundle delivered, issue_count=0x0000.
- Mid-operation reset:
  - Stimulus: assert reset low asynchronously (between edges) with occupancy 2.
  - Response: immediately valid_out=0, ready_in=1, outputs 0, issue_count=0; first post-reset accept proceeds normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                          |
// | Brief    : Shared opcode constants, default widths and bundle types for    |
// |            the ALU issue and writeback stages.                              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;
  localparam int OP_W_DEF    = 5;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  typedef struct packed {
    logic add;
    logic sub;
    logic and_op;
    logic or_op;
    logic sll;
    logic sra;
  } alu_sel_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0]   operand_a;
    logic [WIDTH_DEF-1:0]   operand_b;
    logic [OP_W_DEF-1:0]    opcode;
    logic [SHAMT_W_DEF-1:0] shiftamt;
    alu_sel_t               sel;
  } alu_bundle_t;

endpackage
`default_nettype wire

// File: rtl/alu_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_skid_buffer                                                  |
// | Brief    : Generic 2-entry valid/ready skid buffer with registered ready.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic [1:0]        r_count;
  logic [1:0]        w_count_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_ready;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = (r_count != 2'd0) & i_ready;
  assign o_ready = r_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_main;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Main always holds the oldest entry; skid only ever holds the younger one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
      if (w_pop) begin
        if (r_count == 2'd2) begin
          r_main <= r_skid;
          if (w_push) r_skid <= i_data;
        end else if (w_push) begin
          r_main <= i_data;
        end
      end else if (w_push) begin
        if (r_count == 2'd0) r_main <= i_data;
        else                 r_skid <= i_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_operand_stage                                                |
// | Brief    : Registered ALU issue stage: decode, shift resolution, skid      |
// |            buffering and issue counting.                                    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int OP_W    = OP_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [WIDTH-1:0]   data_operandA_in,
  input  logic [WIDTH-1:0]   data_operandB_in,
  input  logic [OP_W-1:0]    ctrl_ALUopcode_in,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt_in,
  input  logic               ctrl_regshift_in,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [WIDTH-1:0]   data_operandA,
  output logic [WIDTH-1:0]   data_operandB,
  output logic [OP_W-1:0]    ctrl_ALUopcode,
  output logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic               sel_add,
  output logic               sel_sub,
  output logic               sel_and,
  output logic               sel_or,
  output logic               sel_sll,
  output logic               sel_sra,
  output logic [15:0]        issue_count
);

  typedef struct packed {
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   operand_b;
    logic [OP_W-1:0]    opcode;
    logic [SHAMT_W-1:0] shiftamt;
    alu_sel_t           sel;
  } stage_bundle_t;

  localparam int BUNDLE_W = $bits(stage_bundle_t);

  alu_sel_t           w_sel;
  logic [SHAMT_W-1:0] w_shiftamt;
  stage_bundle_t      w_in_bundle;
  stage_bundle_t      w_out_bundle;
  logic               w_valid_out;
  logic [15:0]        r_issue_count;

  always_comb begin
    w_sel = '0;
    case (ctrl_ALUopcode_in)
      OP_W'(OP_ADD): w_sel.add    = 1'b1;
      OP_W'(OP_SUB): w_sel.sub    = 1'b1;
      OP_W'(OP_AND): w_sel.and_op = 1'b1;
      OP_W'(OP_OR):  w_sel.or_op  = 1'b1;
      OP_W'(OP_SLL): w_sel.sll    = 1'b1;
      OP_W'(OP_SRA): w_sel.sra    = 1'b1;
      default:       w_sel        = '0;
    endcase
  end

  // Resolved amount is captured with the bundle so the shifters never see B.
  assign w_shiftamt = ctrl_regshift_in ? data_operandB_in[SHAMT_W-1:0] : ctrl_shiftamt_in;

  assign w_in_bundle.operand_a = data_operandA_in;
  assign w_in_bundle.operand_b = data_operandB_in;
  assign w_in_bundle.opcode    = ctrl_ALUopcode_in;
  assign w_in_bundle.shiftamt  = w_shiftamt;
  assign w_in_bundle.sel       = w_sel;

  alu_skid_buffer #(
    .DATA_W (BUNDLE_W)
  ) u_skid (
    .clk     (clock),
    .rst_n   (reset),
    .i_valid (valid_in),
    .o_ready (ready_in),
    .i_data  (w_in_bundle),
    .o_valid (w_valid_out),
    .i_ready (ready_out),
    .o_data  (w_out_bundle)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_issue_count <= 16'd0;
    end else if (w_valid_out && ready_out) begin
      r_issue_count <= r_issue_count + 16'd1;
    end
  end

  assign valid_out      = w_valid_out;
  assign data_operandA  = w_out_bundle.operand_a;
  assign data_operandB  = w_out_bundle.operand_b;
  assign ctrl_ALUopcode = w_out_bundle.opcode;
  assign ctrl_shiftamt  = w_out_bundle.shiftamt;
  assign sel_add        = w_out_bundle.sel.add;
  assign sel_sub        = w_out_bundle.sel.sub;
  assign sel_and        = w_out_bundle.sel.and_op;
  assign sel_or         = w_out_bundle.sel.or_op;
  assign sel_sll        = w_out_bundle.sel.sll;
  assign sel_sra        = w_out_bundle.sel.sra;
  assign issue_count    = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// Self-checking bench for alu_operand_stage: scoreboard on the output handshake
// plus per-scenario checks of ready_in, stall hold, decode and counter wrap.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clock, reset;
  logic        valid_in, ready_in, valid_out, ready_out;
  logic [31:0] data_operandA_in, data_operandB_in, data_operandA, data_operandB;
  logic [4:0]  ctrl_ALUopcode_in, ctrl_shiftamt_in, ctrl_ALUopcode, ctrl_shiftamt;
  logic        ctrl_regshift_in;
  logic        sel_add, sel_sub, sel_and, sel_or, sel_sll, sel_sra;
  logic [15:0] issue_count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [5:0]  sel;
  } exp_t;

  exp_t        q_exp[$];
  exp_t        w_obs;
  exp_t        mon_e;
  exp_t        snap_prev;
  logic        stalled_prev;
  logic [15:0] m_issue;
  logic [5:0]  w_sel_obs;
  int          n_assert = 0;
  int          n_fail   = 0;

  alu_operand_stage dut (
    .clock             (clock),
    .reset             (reset),
    .valid_in          (valid_in),
    .ready_in          (ready_in),
    .data_operandA_in  (data_operandA_in),
    .data_operandB_in  (data_operandB_in),
    .ctrl_ALUopcode_in (ctrl_ALUopcode_in),
    .ctrl_shiftamt_in  (ctrl_shiftamt_in),
    .ctrl_regshift_in  (ctrl_regshift_in),
    .valid_out         (valid_out),
    .ready_out         (ready_out),
    .data_operandA     (data_operandA),
    .data_operandB     (data_operandB),
    .ctrl_ALUopcode    (ctrl_ALUopcode),
    .ctrl_shiftamt     (ctrl_shiftamt),
    .sel_add           (sel_add),
    .sel_sub           (sel_sub),
    .sel_and           (sel_and),
    .sel_or            (sel_or),
    .sel_sll           (sel_sll),
    .sel_sra           (sel_sra),
    .issue_count       (issue_count)
  );

  assign w_sel_obs = {sel_add, sel_sub, sel_and, sel_or, sel_sll, sel_sra};
  assign w_obs     = {data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, w_sel_obs};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [5:0] model_sel(input logic [4:0] op);
    case (op)
      5'd0:    return 6'b100000;
      5'd1:    return 6'b010000;
      5'd2:    return 6'b001000;
      5'd3:    return 6'b000100;
      5'd4:    return 6'b000010;
      5'd5:    return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic exp_t model_bundle(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op, input logic [4:0] sh,
                                        input logic rs);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.op  = op;
    e.sh  = rs ? b[4:0] : sh;
    e.sel = model_sel(op);
    return e;
  endfunction

  // Scoreboard, issue counter model and stall-hold checker.
  always @(negedge clock) begin
    if (!reset) begin
      q_exp.delete();
      m_issue      = 16'd0;
      stalled_prev = 1'b0;
    end else begin
      n_assert++;
      if (issue_count !== m_issue) begin
        n_fail++;
        $display("FAIL issue_count_track: got %h expected %h at %0t", issue_count, m_issue, $time);
      end
      if (valid_out && ready_out) begin
        n_assert++;
        if (q_exp.size() == 0) begin
          n_fail++;
          $display("FAIL out_underflow: got bundle %h expected none at %0t", w_obs, $time);
        end else begin
          mon_e = q_exp.pop_front();
          if (w_obs !== mon_e) begin
            n_fail++;
            $display("FAIL bundle_out: got %h expected %h at %0t", w_obs, mon_e, $time);
          end
        end
        m_issue = m_issue + 16'd1;
      end
      if (valid_in && ready_in)
        q_exp.push_back(model_bundle(data_operandA_in, data_operandB_in, ctrl_ALUopcode_in,
                                     ctrl_shiftamt_in, ctrl_regshift_in));
      if (valid_out && !ready_out) begin
        if (stalled_prev) begin
          n_assert++;
          if (w_obs !== snap_prev) begin
            n_fail++;
            $display("FAIL stall_hold: got %h expected %h at %0t", w_obs, snap_prev, $time);
          end
        end
        snap_prev    = w_obs;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic [4:0] sh, input logic rs);
    valid_in          = v;
    data_operandA_in  = a;
    data_operandB_in  = b;
    ctrl_ALUopcode_in = op;
    ctrl_shiftamt_in  = sh;
    ctrl_regshift_in  = rs;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    ready_out = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    n_assert++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    n_assert++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b expected 1", ready_in); end
    n_assert++; if (w_obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", w_obs); end
    n_assert++; if (issue_count !== 16'd0) begin n_fail++; $display("FAIL reset_issue_count: got %h expected 0", issue_count); end
    #1 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single_op;
    ready_out = 1'b1;
    drive(1'b1, 32'h0000_0001, 32'd0, OP_SLL, 5'd5, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    n_assert++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", valid_out); end
    n_assert++; if (ctrl_shiftamt !== 5'd5) begin n_fail++; $display("FAIL single_shamt: got %0d expected 5", ctrl_shiftamt); end
    n_assert++; if (w_sel_obs !== 6'b000010) begin n_fail++; $display("FAIL single_sel: got %b expected 000010", w_sel_obs); end
    @(posedge clock); #1;
    n_assert++; if (issue_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %h expected 1", issue_count); end
    n_assert++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b expected 0", valid_out); end
  endtask

  task automatic test_regshift;
    drive(1'b1, 32'h0000_0010, 32'hFFFF_FFE3, OP_SRA, 5'd7, 1'b1);
    @(posedge clock); #1;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    n_assert++; if (ctrl_shiftamt !== 5'd3) begin n_fail++; $display("FAIL regshift_shamt: got %0d expected 3", ctrl_shiftamt); end
    n_assert++; if (data_operandB !== 32'hFFFF_FFE3) begin n_fail++; $display("FAIL regshift_b: got %h expected ffffffe3", data_operandB); end
    n_assert++; if (w_sel_obs !== 6'b000001) begin n_fail++; $display("FAIL regshift_sel: got %b expected 000001", w_sel_obs); end
    @(posedge clock); #1;
    n_assert++; if (issue_count !== 16'd2) begin n_fail++; $display("FAIL regshift_count: got %h expected 2", issue_count); end
  endtask

  task automatic test_backpressure;
    ready_out = 1'b0;
    drive(1'b1, 32'd1, 32'h101, OP_ADD, 5'd1, 1'b0);
    @(posedge clock); #1;
    n_assert++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL bp_ready_occ1: got %b expected 1", ready_in); end
    drive(1'b1, 32'd2, 32'h102, OP_AND, 5'd2, 1'b0);
    @(posedge clock); #1;
    n_assert++; if (ready_in !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", ready_in); end
    drive(1'b1, 32'd3, 32'h103, OP_OR, 5'd3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      n_assert++; if (ready_in !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %b expected 0", ready_in); end
      n_assert++; if (data_operandA !== 32'd1 || valid_out !== 1'b1) begin
        n_fail++; $display("FAIL bp_head: got A=%h valid=%b expected A=1 valid=1", data_operandA, valid_out);
      end
    end
  endtask

  task automatic test_drain;
    ready_out = 1'b1;
    @(posedge clock); #1;
    n_assert++; if (data_operandA !== 32'd2 || ready_in !== 1'b1) begin
      n_fail++; $display("FAIL drain_e1: got A=%h ready_in=%b expected A=2 ready_in=1", data_operandA, ready_in);
    end
    @(posedge clock); #1;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    n_assert++; if (data_operandA !== 32'd3 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL drain_e2: got A=%h valid=%b expected A=3 valid=1", data_operandA, valid_out);
    end
    @(posedge clock); #1;
    n_assert++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", valid_out); end
    n_assert++; if (issue_count !== 16'd5) begin n_fail++; $display("FAIL drain_count: got %h expected 5", issue_count); end
    @(posedge clock); #1;
    n_assert++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b expected 1", ready_in); end
  endtask

  task automatic test_wrap;
    ready_out = 1'b1;
    for (int i = 0; i < 65530; i++) begin
      drive(1'b1, $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom), 1'($urandom));
      @(posedge clock); #1;
    end
    drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'b11111, 5'd9, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    n_assert++; if (issue_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", issue_count); end
    n_assert++; if (w_sel_obs !== 6'b000000) begin n_fail++; $display("FAIL unknown_op_sel: got %b expected 000000", w_sel_obs); end
    n_assert++; if (ctrl_ALUopcode !== 5'b11111 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL unknown_op_pass: got op=%b valid=%b expected op=11111 valid=1", ctrl_ALUopcode, valid_out);
    end
    @(posedge clock); #1;
    n_assert++; if (issue_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h expected 0000", issue_count); end
  endtask

  task automatic test_mid_reset;
    ready_out = 1'b1;
    drive(1'b1, 32'hA0, 32'hB0, OP_ADD, 5'd0, 1'b0);
    @(posedge clock); #1;
    drive(1'b1, 32'hA1, 32'hB1, OP_SUB, 5'd1, 1'b0);
    @(posedge clock); #1;
    ready_out = 1'b0;
    drive(1'b1, 32'hA2, 32'hB2, OP_SLL, 5'd2, 1'b0);
    @(posedge clock); #1;
    n_assert++; if (ready_in !== 1'b0 || issue_count !== 16'd1) begin
      n_fail++; $display("FAIL midrst_prefill: got ready_in=%b count=%h expected 0/0001", ready_in, issue_count);
    end
    #2 reset = 1'b0;
    #1;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    n_assert++; if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      n_fail++; $display("FAIL midrst_hs: got valid=%b ready_in=%b expected 0/1", valid_out, ready_in);
    end
    n_assert++; if (w_obs !== '0 || issue_count !== 16'd0) begin
      n_fail++; $display("FAIL midrst_clear: got %h count=%h expected 0/0", w_obs, issue_count);
    end
    @(posedge clock); #1;
    reset     = 1'b1;
    ready_out = 1'b1;
    drive(1'b1, 32'h55, 32'h66, OP_SUB, 5'd3, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    n_assert++; if (valid_out !== 1'b1 || data_operandA !== 32'h55 || w_sel_obs !== 6'b010000) begin
      n_fail++; $display("FAIL postrst_accept: got valid=%b A=%h sel=%b expected 1/55/010000", valid_out, data_operandA, w_sel_obs);
    end
    @(posedge clock); #1;
    n_assert++; if (issue_count !== 16'd1 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL postrst_count: got count=%h valid=%b expected 0001/0", issue_count, valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_regshift();
    test_backpressure();
    test_drain();
    test_wrap();
    test_mid_reset();
    @(negedge clock);
    n_assert++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
